weighted_sum_accum: RTL and testbench
=====================================

WEIGHTED_SUM_ACCUM -- requirements
Module: weighted_sum_accum

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: multiply lanes per beat; any value >= 1.
REQ-002 SHALL have parameter BIT_LENGTH, default 8: unsigned operand width.
REQ-003 SHALL have parameter APPROX_BITS, default 2: operand LSBs zeroed in approximate mode; range 0 to BIT_LENGTH-1.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*BIT_LENGTH+$clog2(NUM_INPUTS)+8: accumulator and output width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 mode  in  1  0 = exact, 1 = approximate; sampled on the first beat of each vector.
REQ-008 in_valid  in  1  beat present.
REQ-009 in_ready  out  1  block accepts a beat.
REQ-010 in_last  in  1  final beat of the current vector.
REQ-011 weights  in  NUM_INPUTS x BIT_LENGTH  packed per-lane weights.
REQ-012 inputs  in  NUM_INPUTS x BIT_LENGTH  packed per-lane activations.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_sum  out  ACC_WIDTH  accumulated weighted sum.
REQ-016 out_sat  out  1  the accumulator saturated during this vector.
REQ-017 out_beats  out  16  number of beats in this vector; saturates at 16'hFFFF.

Function
REQ-018 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 Lane i product SHALL be weights[i]*inputs[i], full 2*BIT_LENGTH bits, unsigned; in approximate mode both operands first have their low APPROX_BITS bits forced to 0.
REQ-020 Products SHALL be registered on the accepting edge E; at edge E+1 their zero-extended sum SHALL be added to the accumulator.
REQ-021 Accumulator addition SHALL saturate at 2^ACC_WIDTH-1 and set a sticky saturation flag for the vector.
REQ-022 FSM states: IDLE, ACCUM, DRAIN, OUT.
  - IDLE: accepting a beat -> ACCUM, or -> DRAIN if in_last; the first beat loads the accumulator rather than adding to it.
  - ACCUM: an accepted beat with in_last -> DRAIN.
  - DRAIN: one cycle -> OUT.
  - OUT: out_valid = 1; on out_valid & out_ready -> IDLE.
REQ-023 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN and OUT.
REQ-024 Latency: with the last beat accepted at edge E, out_valid SHALL be 1 from edge E+2 onward.
REQ-025 Back-to-back beats SHALL be accepted every cycle with no bubbles.
REQ-026 out_sum, out_sat and out_beats SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 After the output handshake, a new vector's first beat SHALL be accepted in the following cycle (IDLE).
REQ-028 A mode change within a vector SHALL be ignored; the value latched on the first beat applies to the whole vector.
REQ-029 in_valid=0 cycles within a vector SHALL hold the state and the accumulator.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the following, including mid-vector or mid-output:
  - state to IDLE;
  - accumulator, product registers, saturation flag and beat count to 0;
  - out_valid=0, out_sum=0, out_sat=0, out_beats=0;
  - in_ready=1.
REQ-031 A partially accumulated vector SHALL be discarded on reset.

Structure
REQ-032 A shared package SHALL hold the state enum and the width helper functions: product width, tree width and default ACC_WIDTH.
REQ-033 One sub-module, wsa_mult_lane, SHALL implement a single registered lane: mode-dependent operand truncation plus the multiply; it is instantiated NUM_INPUTS times.

Verification
REQ-034 Exact mode, N=4, B=8, one beat (last): weights {1,2,3,4}, inputs {10,10,10,10} -> out_sum=100, out_beats=1, out_valid at E+2.
REQ-035 Approx mode, APPROX_BITS=2, one beat: weights {7,7,7,7}, inputs {5,5,5,5} -> operands 4 and 4, out_sum=64.
REQ-036 Three back-to-back beats of all 255 operands, exact -> out_sum=780300, out_beats=3, out_sat=0, in_ready high for all three beats.
REQ-037 ACC_WIDTH=16, two beats of all 255 operands -> out_sum=65535, out_sat=1.
REQ-038 out_ready held 0 for 5 cycles -> outputs stable and in_ready=0; after the handshake, the next vector is accepted the next cycle.
REQ-039 rst_n pulsed low mid-vector after 2 beats -> all outputs at reset values; the next vector's result excludes the discarded beats.

Source files
------------

// File: rtl/weighted_sum_accum_pkg.sv
// Shared types and width helpers for the weighted-sum accumulator.
package weighted_sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  function automatic int prod_width(input int bit_length);
    return 2 * bit_length;
  endfunction

  function automatic int tree_width(input int bit_length, input int num_inputs);
    return prod_width(bit_length) + $clog2(num_inputs);
  endfunction

  function automatic int default_acc_width(input int bit_length, input int num_inputs);
    return tree_width(bit_length, num_inputs) + 8;
  endfunction

endpackage

// File: rtl/wsa_mult_lane.sv
// One registered multiply lane with optional LSB truncation of both operands.
module wsa_mult_lane
  import weighted_sum_accum_pkg::*;
#(
  parameter int BIT_LENGTH  = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic                                approx,
  input  logic [BIT_LENGTH-1:0]               weight,
  input  logic [BIT_LENGTH-1:0]               act,
  output logic [prod_width(BIT_LENGTH)-1:0]   product
);

  localparam int PW = prod_width(BIT_LENGTH);
  localparam logic [BIT_LENGTH-1:0] KEEP_MASK = {BIT_LENGTH{1'b1}} << APPROX_BITS;

  logic [BIT_LENGTH-1:0] w_op;
  logic [BIT_LENGTH-1:0] a_op;

  always_comb begin
    w_op = approx ? (weight & KEEP_MASK) : weight;
    a_op = approx ? (act & KEEP_MASK) : act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (load) begin
      product <= PW'(w_op) * PW'(a_op);
    end
  end

endmodule

// File: rtl/weighted_sum_accum.sv
// Streaming multi-lane multiply-accumulate with saturation and a valid/ready result port.
module weighted_sum_accum
  import weighted_sum_accum_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int BIT_LENGTH  = 8,
  parameter int APPROX_BITS = 2,
  parameter int ACC_WIDTH   = default_acc_width(BIT_LENGTH, NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [NUM_INPUTS*BIT_LENGTH-1:0] weights,
  input  logic [NUM_INPUTS*BIT_LENGTH-1:0] inputs,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_sum,
  output logic                             out_sat,
  output logic [15:0]                      out_beats
);

  localparam int PW = prod_width(BIT_LENGTH);
  localparam int TW = tree_width(BIT_LENGTH, NUM_INPUTS);
  localparam int SW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;

  state_t                state;
  logic                  mode_q;
  logic                  accept;
  logic                  lane_approx;
  logic [PW-1:0]         prod [NUM_INPUTS];
  logic [TW-1:0]         tree_sum;
  logic                  p_valid;
  logic                  p_first;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  acc_sat;
  logic [15:0]           beat_cnt;
  logic [SW-1:0]         add_full;
  logic                  add_ovf;
  logic [ACC_WIDTH-1:0]  add_sat;

  always_comb begin
    in_ready    = (state == IDLE) || (state == ACCUM);
    accept      = in_valid && in_ready;
    // The first beat uses the live mode; later beats use the value latched with it.
    lane_approx = (state == IDLE) ? mode : mode_q;
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    wsa_mult_lane #(
      .BIT_LENGTH (BIT_LENGTH),
      .APPROX_BITS(APPROX_BITS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .approx (lane_approx),
      .weight (weights[g*BIT_LENGTH +: BIT_LENGTH]),
      .act    (inputs[g*BIT_LENGTH +: BIT_LENGTH]),
      .product(prod[g])
    );
  end

  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      tree_sum = tree_sum + TW'(prod[i]);
    end
  end

  always_comb begin
    add_full = SW'(p_first ? {ACC_WIDTH{1'b0}} : acc) + SW'(tree_sum);
    add_ovf  = |add_full[SW-1:ACC_WIDTH];
    add_sat  = add_ovf ? '1 : add_full[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      acc     <= '0;
      acc_sat <= 1'b0;
    end else begin
      p_valid <= accept;
      p_first <= accept && (state == IDLE);
      if (p_valid) begin
        acc     <= add_sat;
        acc_sat <= (p_first ? 1'b0 : acc_sat) | add_ovf;
      end
    end
  end

  // OUT spends its first cycle capturing the accumulator, which settles one edge
  // after DRAIN; out_valid therefore rises two edges after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q   <= mode;
            beat_cnt <= 16'd1;
            state    <= in_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 16'd1;
            if (in_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= OUT;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sum   <= acc;
            out_sat   <= acc_sat;
            out_beats <= beat_cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sum_accum.sv
// Self-checking bench: table-driven single-beat vectors, hand sequences and a random scoreboard run.
module tb_weighted_sum_accum;

  localparam int N  = 4;
  localparam int B  = 8;
  localparam int AB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] weights = '0;
  logic [31:0] inputs = '0;

  logic        in_ready, out_valid, out_sat;
  logic [25:0] out_sum;
  logic [15:0] out_beats;
  logic        in_ready16, out_valid16, out_sat16;
  logic [15:0] out_sum16;
  logic [15:0] out_beats16;

  weighted_sum_accum #(
    .NUM_INPUTS(N), .BIT_LENGTH(B), .APPROX_BITS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .weights(weights), .inputs(inputs), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat), .out_beats(out_beats)
  );

  weighted_sum_accum #(
    .NUM_INPUTS(N), .BIT_LENGTH(B), .APPROX_BITS(AB), .ACC_WIDTH(16)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready16),
    .in_last(in_last), .weights(weights), .inputs(inputs), .out_valid(out_valid16),
    .out_ready(out_ready), .out_sum(out_sum16), .out_sat(out_sat16), .out_beats(out_beats16)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [63:0] sum;
    logic        sat;
    logic [63:0] sum16;
    logic        sat16;
    logic [15:0] beats;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   stall_left = 0;
  int   hs_cycle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [63:0] total, input int beats);
    exp_t e;
    logic [63:0] max26 = 64'h3FF_FFFF;
    e.sum   = (total > max26) ? max26 : total;
    e.sat   = (total > max26);
    e.sum16 = (total > 64'd65535) ? 64'd65535 : total;
    e.sat16 = (total > 64'd65535);
    e.beats = (beats > 65535) ? 16'hFFFF : 16'(beats);
    return e;
  endfunction

  function automatic logic [63:0] beat_model(input logic [31:0] w, input logic [31:0] x, input logic m);
    logic [63:0] s;
    int a, b;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = int'(w[8*i +: 8]);
      b = int'(x[8*i +: 8]);
      if (m) begin
        a = (a / 4) * 4;
        b = (b / 4) * 4;
      end
      s += 64'(a * b);
    end
    return s;
  endfunction

  // Output monitor: owns out_ready, stalls when asked, pops the scoreboard once per result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        out_ready = 1'b1;
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else if (stall_left > 0) begin
        out_ready = 1'b0;
        check("stall_sum", 64'(out_sum), sb[0].sum);
        check("stall_beats", 64'(out_beats), 64'(sb[0].beats));
        check("stall_sat", 64'(out_sat), 64'(sb[0].sat));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        stall_left--;
      end else begin
        out_ready = 1'b1;
        mon_e = sb.pop_front();
        check("out_sum", 64'(out_sum), mon_e.sum);
        check("out_sat", 64'(out_sat), 64'(mon_e.sat));
        check("out_beats", 64'(out_beats), 64'(mon_e.beats));
        check("out_valid16", 64'(out_valid16), 64'd1);
        check("out_sum16", 64'(out_sum16), mon_e.sum16);
        check("out_sat16", 64'(out_sat16), 64'(mon_e.sat16));
        hs_cycle = cycle + 1;
      end
    end else begin
      out_ready = (stall_left == 0);
    end
  end

  task automatic send_beat(input logic [31:0] w, input logic [31:0] x, input logic m,
                           input logic last, output int waited, output int acc_cyc);
    @(negedge clk);
    in_valid = 1'b1;
    weights  = w;
    inputs   = x;
    mode     = m;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cycle;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    check({tag, "_out_sat"}, 64'(out_sat), 64'd0);
    check({tag, "_out_beats"}, 64'(out_beats), 64'd0);
    check({tag, "_out_valid16"}, 64'(out_valid16), 64'd0);
    check({tag, "_out_sum16"}, 64'(out_sum16), 64'd0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    logic        m;
    logic [63:0] sum;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int w0, w1, w2, ac0, ac1, ac2;
    logic [63:0] total;
    logic        vm, m;
    logic [31:0] rw, rx;
    int          len;

    tbl[0] = '{32'h04030201, 32'h0A0A0A0A, 1'b0, 64'd100};
    tbl[1] = '{32'h07070707, 32'h05050505, 1'b1, 64'd64};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'd260100};
    tbl[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 64'd0};
    tbl[4] = '{32'h03030303, 32'hFFFFFFFF, 1'b1, 64'd0};
    tbl[5] = '{32'h000000C8, 32'h00000064, 1'b0, 64'd20000};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd254016};
    tbl[7] = '{32'h08102040, 32'h01020304, 1'b0, 64'd392};

    #3;
    check_reset_vals("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sb.push_back(make_exp(tbl[i].sum, 1));
      send_beat(tbl[i].w, tbl[i].x, tbl[i].m, 1'b1, w0, ac0);
      idle_in();
      check("lat_e0_valid", 64'(out_valid), 64'd0);
      check("lat_e0_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("lat_e1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat_e2_valid", 64'(out_valid), 64'd1);
      wait_drain();
    end

    // Three back-to-back full-scale beats.
    sb.push_back(make_exp(64'd780300, 3));
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, w0, ac0);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, w1, ac1);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, w2, ac2);
    check("b2b_wait", 64'(w0 + w1 + w2), 64'd0);
    check("b2b_gap1", 64'(ac1 - ac0), 64'd1);
    check("b2b_gap2", 64'(ac2 - ac1), 64'd1);
    idle_in();
    wait_drain();

    // Two full-scale beats: saturates the 16-bit instance only.
    sb.push_back(make_exp(64'd520200, 2));
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, w0, ac0);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, w0, ac0);
    idle_in();
    wait_drain();

    // Mode flipped on the second beat must be ignored.
    sb.push_back(make_exp(64'd128, 2));
    send_beat(32'h07070707, 32'h05050505, 1'b1, 1'b0, w0, ac0);
    send_beat(32'h07070707, 32'h05050505, 1'b0, 1'b1, w0, ac0);
    idle_in();
    wait_drain();

    // in_valid gap inside a vector.
    sb.push_back(make_exp(64'd200, 2));
    send_beat(32'h04030201, 32'h0A0A0A0A, 1'b0, 1'b0, w0, ac0);
    idle_in();
    repeat (3) @(negedge clk);
    check("gap_out_valid", 64'(out_valid), 64'd0);
    check("gap_in_ready", 64'(in_ready), 64'd1);
    send_beat(32'h04030201, 32'h0A0A0A0A, 1'b0, 1'b1, w0, ac0);
    idle_in();
    wait_drain();

    // Output stalled for 5 cycles, then next vector on the cycle after the handshake.
    stall_left = 5;
    sb.push_back(make_exp(64'd100, 1));
    send_beat(32'h04030201, 32'h0A0A0A0A, 1'b0, 1'b1, w0, ac0);
    sb.push_back(make_exp(64'd64, 1));
    send_beat(32'h07070707, 32'h05050505, 1'b1, 1'b1, w0, ac0);
    check("stall_consumed", 64'(stall_left), 64'd0);
    check("next_accept_cycle", 64'(ac0), 64'(hs_cycle + 1));
    idle_in();
    wait_drain();

    // Reset mid-vector discards the partial sum.
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, w0, ac0);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, w0, ac0);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(make_exp(64'd100, 1));
    send_beat(32'h04030201, 32'h0A0A0A0A, 1'b0, 1'b1, w0, ac0);
    idle_in();
    wait_drain();

    // Random vectors against the behavioural model.
    for (int v = 0; v < 6; v++) begin
      len   = $urandom_range(1, 4);
      total = 0;
      vm    = 1'b0;
      for (int b = 0; b < len; b++) begin
        rw = $urandom;
        rx = $urandom;
        m  = 1'($urandom_range(0, 1));
        if (b == 0) vm = m;
        total += beat_model(rw, rx, vm);
        send_beat(rw, rx, m, (b == len - 1), w0, ac0);
        if (b != len - 1 && $urandom_range(0, 1) == 1) idle_in();
      end
      sb.push_back(make_exp(total, len));
      idle_in();
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
